counter_369_checker: RTL and testbench

Receiving-end monitor for the 369-game counter sequence (0, 3, 6, 9, 13, 6, 9, 13, …). It samples a 4-bit count stream and predicts the next value. It reports lock, mismatches, claps and period completions. It sits beside any 369 counter instance in the lab designs as a self-checking consumer of its `count` bus, in-circuit or in a bench.

---
 rtl/counter_369_pkg.sv | 29 ++
 rtl/seq369_next.sv | 21 ++
 rtl/counter_369_checker.sv | 96 +++++++++
 tb/tb_counter_369_checker.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/counter_369_pkg.sv
// Shared definitions for the 369-game sequence checker: tracking states,
// sequence values and the state-to-prediction mapping.
package counter_369_pkg;

  typedef enum logic [2:0] {
    HUNT = 3'd0,
    E3   = 3'd1,
    E6   = 3'd2,
    E9   = 3'd3,
    E13  = 3'd4
  } chk_state_t;

  localparam logic [3:0] SEQ_0  = 4'd0;
  localparam logic [3:0] SEQ_3  = 4'd3;
  localparam logic [3:0] SEQ_6  = 4'd6;
  localparam logic [3:0] SEQ_9  = 4'd9;
  localparam logic [3:0] SEQ_13 = 4'd13;

  function automatic logic [3:0] state_expected(input chk_state_t s);
    case (s)
      E3:      return SEQ_3;
      E6:      return SEQ_6;
      E9:      return SEQ_9;
      E13:     return SEQ_13;
      default: return SEQ_0;
    endcase
  endfunction

endpackage

// File: rtl/seq369_next.sv
// Successor of a tracking state when the observed sample matches its prediction.
// After 13 the game restarts at 6, never at 0.
module seq369_next
  import counter_369_pkg::*;
(
  input  chk_state_t state,
  output chk_state_t next_state
);

  always_comb begin
    case (state)
      HUNT:    next_state = E3;
      E3:      next_state = E6;
      E6:      next_state = E9;
      E9:      next_state = E13;
      E13:     next_state = E6;
      default: next_state = HUNT;
    endcase
  end

endmodule

// File: rtl/counter_369_checker.sv
// Receive-side monitor for a 369 counter: predicts each sample, tracks lock,
// and reports mismatches, claps and completed periods as one-cycle pulses.
module counter_369_checker
  import counter_369_pkg::*;
#(
  parameter int LOCK_N = 2,
  parameter int ERR_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [3:0]       count_in,
  output logic [3:0]       expected,
  output logic             locked,
  output logic             mismatch,
  output logic             clap,
  output logic             period_done,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [3:0] LOCK_V = 4'(LOCK_N);

  chk_state_t       state, state_n, succ;
  logic [3:0]       mcnt, mcnt_n;
  logic [ERR_W-1:0] err_n;
  logic             locked_n, mismatch_n, clap_n, period_done_n;

  seq369_next u_next (
    .state      (state),
    .next_state (succ)
  );

  assign expected = state_expected(state);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= HUNT;
      mcnt        <= 4'd0;
      err_count   <= '0;
      locked      <= 1'b0;
      mismatch    <= 1'b0;
      clap        <= 1'b0;
      period_done <= 1'b0;
    end else begin
      state       <= state_n;
      mcnt        <= mcnt_n;
      err_count   <= err_n;
      locked      <= locked_n;
      mismatch    <= mismatch_n;
      clap        <= clap_n;
      period_done <= period_done_n;
    end
  end

  always_comb begin
    state_n       = state;
    mcnt_n        = mcnt;
    err_n         = err_count;
    locked_n      = locked;
    mismatch_n    = 1'b0;
    clap_n        = 1'b0;
    period_done_n = 1'b0;
    if (in_valid) begin
      if (state == HUNT) begin
        // While hunting only a 0 starts tracking; anything else is ignored.
        if (count_in == SEQ_0) begin
          state_n  = E3;
          mcnt_n   = 4'd1;
          locked_n = (4'd1 >= LOCK_V);
        end else begin
          mcnt_n   = 4'd0;
          locked_n = 1'b0;
        end
      end else if (count_in == expected) begin
        state_n = succ;
        if (mcnt < LOCK_V) mcnt_n = mcnt + 4'd1;
        locked_n      = (mcnt_n >= LOCK_V);
        clap_n        = 1'b1;
        period_done_n = (state == E13);
      end else begin
        mismatch_n = 1'b1;
        locked_n   = 1'b0;
        if (err_count != '1) err_n = err_count + ERR_W'(1);
        // A 0 after a break is taken as a counter restart rather than noise.
        if (count_in == SEQ_0) begin
          state_n = E3;
          mcnt_n  = 4'd1;
        end else begin
          state_n = HUNT;
          mcnt_n  = 4'd0;
        end
      end
    end
  end

endmodule

// File: tb/tb_counter_369_checker.sv
// Directed bench for counter_369_checker: default instance plus a 2-bit error
// counter instance sharing the same input stream.
module tb_counter_369_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [3:0] count_in;

  logic [3:0] expected, expected2;
  logic       locked, mismatch, clap, period_done;
  logic       locked2, mismatch2, clap2, period_done2;
  logic [7:0] err_count;
  logic [1:0] err_count2;

  int checks = 0;
  int errors = 0;
  int n_clap, n_pd, n_mis, n_mis2;

  always #5 clk = ~clk;

  counter_369_checker #(.LOCK_N(2), .ERR_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .count_in(count_in),
    .expected(expected), .locked(locked), .mismatch(mismatch), .clap(clap),
    .period_done(period_done), .err_count(err_count)
  );

  counter_369_checker #(.LOCK_N(2), .ERR_W(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .count_in(count_in),
    .expected(expected2), .locked(locked2), .mismatch(mismatch2), .clap(clap2),
    .period_done(period_done2), .err_count(err_count2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive at the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic v, input logic [3:0] c);
    @(negedge clk);
    in_valid = v;
    count_in = c;
    @(posedge clk);
    #1;
    n_clap += clap;
    n_pd   += period_done;
    n_mis  += mismatch;
    n_mis2 += mismatch2;
    if (clap && mismatch) chk("clap_and_mismatch", 1, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    count_in = 4'd0;
    @(negedge clk);
    reset = 1'b0;
    n_clap = 0; n_pd = 0; n_mis = 0; n_mis2 = 0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; count_in = 4'd0;
    n_clap = 0; n_pd = 0; n_mis = 0; n_mis2 = 0;
    #12;
    chk("rst_expected", expected, 0);
    chk("rst_locked", locked, 0);
    chk("rst_mismatch", mismatch, 0);
    chk("rst_clap", clap, 0);
    chk("rst_period_done", period_done, 0);
    chk("rst_err", err_count, 0);

    // Clean stream 0,3,6,9,13,6,9,13
    do_reset();
    step(1, 0);  chk("t1_lock_after0", locked, 0); chk("t1_exp_after0", expected, 3);
    step(1, 3);  chk("t1_lock_after3", locked, 1);
    step(1, 6);  step(1, 9);
    step(1, 13); chk("t1_pd_first13", period_done, 1); chk("t1_exp_wrap", expected, 6);
    step(1, 6);  chk("t1_pd_one_cycle", period_done, 0);
    step(1, 9);  step(1, 13);
    chk("t1_claps", n_clap, 7);
    chk("t1_periods", n_pd, 2);
    chk("t1_err", err_count, 0);
    chk("t1_exp_end", expected, 6);
    step(0, 6);  chk("t1_gap_clap", clap, 0); chk("t1_gap_exp", expected, 6);
    chk("t1_gap_locked", locked, 1);

    // Noise while hunting
    do_reset();
    step(1, 5); step(1, 7);
    chk("t2_exp_hunt", expected, 0);
    step(1, 0); step(1, 3);
    chk("t2_mismatches", n_mis, 0);
    chk("t2_locked", locked, 1);
    chk("t2_err", err_count, 0);
    chk("t2_exp", expected, 6);

    // Break at 10 then resync on 0
    do_reset();
    step(1, 0); step(1, 3); step(1, 6);
    step(1, 10);
    chk("t3_mismatch", mismatch, 1);
    chk("t3_clap_at10", clap, 0);
    chk("t3_locked_after10", locked, 0);
    chk("t3_err", err_count, 1);
    chk("t3_exp_hunt", expected, 0);
    step(1, 0);
    chk("t3_mis_one_cycle", mismatch, 0);
    chk("t3_locked_after0", locked, 0);
    chk("t3_exp_after0", expected, 3);
    step(1, 3); chk("t3_relock", locked, 1);
    step(1, 6); chk("t3_exp_9", expected, 9);
    chk("t3_mis_total", n_mis, 1);

    // 13 followed by 0: restart-style break
    step(1, 9); step(1, 13);
    chk("t4_pd", period_done, 1);
    step(1, 0);
    chk("t4_mismatch", mismatch, 1);
    chk("t4_err", err_count, 2);
    chk("t4_exp_e3", expected, 3);
    chk("t4_locked_drop", locked, 0);
    step(1, 3); chk("t4_relock", locked, 1);

    // Gap holds E9 state, then async reset between edges
    step(1, 6);
    chk("t6_exp_9", expected, 9);
    step(0, 4); step(0, 0);
    chk("t6_gap_exp", expected, 9);
    chk("t6_gap_mis", mismatch, 0);
    chk("t6_gap_clap", clap, 0);
    chk("t6_gap_err", err_count, 2);
    chk("t6_gap_locked", locked, 1);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    chk("t6_async_exp", expected, 0);
    chk("t6_async_locked", locked, 0);
    chk("t6_async_err", err_count, 0);
    chk("t6_async_mis", mismatch, 0);
    @(negedge clk); reset = 1'b0;
    step(1, 0); chk("t6_after_rst_exp", expected, 3);

    // Saturation of the 2-bit error counter with back-to-back mismatches
    do_reset();
    step(1, 0); step(1, 3);
    chk("t5_locked2", locked2, 1);
    step(1, 0); chk("t5_err2_1", err_count2, 1);
    step(1, 0); step(1, 0); chk("t5_err2_3", err_count2, 3);
    step(1, 0); chk("t5_err2_sat", err_count2, 3); chk("t5_mis2_sat", mismatch2, 1);
    step(1, 0);
    chk("t5_err2_end", err_count2, 3);
    chk("t5_mis2_pulses", n_mis2, 5);
    chk("t5_err8", err_count, 5);
    chk("t5_exp2", expected2, 3);
    step(0, 0); chk("t5_mis2_gap", mismatch2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
